i2c_seq: RTL

//  Table-driven sequencer for the i2c_master core. It replaces hard-coded FSMs such as a

---
 rtl/i2c_seq_if.sv | 21 ++
 rtl/i2c_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/i2c_seq_if.sv
// Command bus between the table sequencer and a single i2c_master core.
// The master modport is the sequencer side; the slave modport is the core side.
interface i2c_seq_if;
  logic [7:0] data_in;
  logic       ack_in;
  logic [1:0] cmd;
  logic       stb;
  logic [7:0] data_out;
  logic       ack_out;
  logic       ready;

  modport master (
    output data_in, ack_in, cmd, stb,
    input  data_out, ack_out, ready
  );

  modport slave (
    input  data_in, ack_in, cmd, stb,
    output data_out, ack_out, ready
  );
endinterface

// File: rtl/i2c_seq.sv
// Table-driven sequencer for one i2c_master: walks a command ROM and issues START/STOP/WRITE/READ/DELAY.
// state      | meaning
// IDLE       | waiting for go, rdy=1
// FETCH      | ROM read latency cycle
// DECODE     | entry on rom_data, command fields latched
// ISSUE      | waiting for master ready, then one-cycle stb
// WAIT       | master busy; exits on ready (first cycle ignored)
// DELAY      | down-counter running
// ABORT      | STOP strobe after a NAK
// ABORT_WAIT | waiting for the STOP to finish
// DONE       | one-cycle done pulse
module i2c_seq #(
  parameter int AW          = 8,
  parameter int DELAY_SHIFT = 8,
  parameter bit NAK_ABORT   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic [AW-1:0] start_addr,
  output logic          rdy,
  output logic          done,
  output logic          err,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [AW-1:0] rom_addr,
  input  logic [11:0]   rom_data,
  i2c_seq_if.master     i2c
);

  localparam int CW = 8 + DELAY_SHIFT;

  localparam logic [3:0] OP_START = 4'd1;
  localparam logic [3:0] OP_STOP  = 4'd2;
  localparam logic [3:0] OP_WRITE = 4'd3;
  localparam logic [3:0] OP_READ  = 4'd4;
  localparam logic [3:0] OP_DELAY = 4'd5;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_DELAY,
    S_ABORT,
    S_ABORT_WAIT,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] dly_cnt;
  logic          wait_armed;
  logic          ack_seen;
  logic          nak_hit;
  logic          dly_tc;
  logic          master_op;
  logic          stb_c;
  logic [3:0]    op;
  logic [7:0]    arg;

  assign op        = rom_data[11:8];
  assign arg       = rom_data[7:0];
  assign master_op = (op == OP_START) || (op == OP_STOP) || (op == OP_WRITE) || (op == OP_READ);
  assign ack_seen  = wait_armed & i2c.ready;
  assign nak_hit   = (i2c.cmd == CMD_WRITE) & i2c.ack_out;
  // A zero load exits after one cycle, same as a load of one.
  assign dly_tc    = (dly_cnt <= CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stb_c    = 1'b0;
    case (state)
      S_IDLE:   if (go) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        if (master_op)            state_nx = S_ISSUE;
        else if (op == OP_DELAY)  state_nx = S_DELAY;
        else                      state_nx = S_DONE;
      end
      S_ISSUE: begin
        if (i2c.ready) begin
          stb_c    = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack_seen) state_nx = (nak_hit && NAK_ABORT) ? S_ABORT : S_FETCH;
      end
      S_DELAY:  if (dly_tc) state_nx = S_FETCH;
      S_ABORT: begin
        if (i2c.ready) begin
          stb_c    = 1'b1;
          state_nx = S_ABORT_WAIT;
        end
      end
      S_ABORT_WAIT: if (ack_seen) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign i2c.stb = stb_c;
  assign rdy     = (state == S_IDLE);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr    <= '0;
      err         <= 1'b0;
      rd_data     <= 8'h00;
      rd_valid    <= 1'b0;
      i2c.cmd     <= CMD_START;
      i2c.data_in <= 8'h00;
      i2c.ack_in  <= 1'b0;
      dly_cnt     <= '0;
      wait_armed  <= 1'b0;
    end else begin
      rd_valid   <= 1'b0;
      // Ready is only trusted from the second wait cycle on.
      wait_armed <= (state == S_WAIT) || (state == S_ABORT_WAIT);
      case (state)
        S_IDLE: begin
          if (go) begin
            rom_addr <= start_addr;
            err      <= 1'b0;
          end
        end
        S_DECODE: begin
          if (master_op) begin
            i2c.cmd     <= op[1:0] - 2'd1;
            i2c.data_in <= (op == OP_WRITE) ? arg : 8'h00;
            i2c.ack_in  <= (op == OP_READ) ? arg[0] : 1'b0;
          end
          dly_cnt <= CW'(arg) << DELAY_SHIFT;
        end
        S_WAIT: begin
          if (ack_seen) begin
            if (i2c.cmd == CMD_READ) begin
              rd_data  <= i2c.data_out;
              rd_valid <= 1'b1;
            end
            if (nak_hit) err <= 1'b1;
            if (nak_hit && NAK_ABORT) i2c.cmd  <= CMD_STOP;
            else                      rom_addr <= rom_addr + AW'(1);
          end
        end
        S_DELAY: begin
          if (dly_tc) rom_addr <= rom_addr + AW'(1);
          else        dly_cnt  <= dly_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
